stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 118 +++++++++++
 tb/tb_stream_mux_rr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with an internal
// round-robin or fixed-priority arbiter and one output pipeline register.
//
// Parameters:
//   p_nbits   message width in bits
//   p_nchans  number of input channels (>= 2)
//   p_rr      1 = round-robin starting at ptr, 0 = lowest index wins
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_val / in_rdy     per-channel handshake (in_rdy is combinational)
//   in_msg              channel i at bits [i*p_nbits +: p_nbits]
//   out_val / out_rdy   output handshake (out_val registered)
//   out_msg             registered message
//   out_sel             index of the channel that supplied out_msg
module stream_mux_rr #(
    parameter int unsigned p_nbits  = 4,
    parameter int unsigned p_nchans = 2,
    parameter int unsigned p_rr     = 1,
    localparam int unsigned c_selbits = (p_nchans > 2) ? $clog2(p_nchans) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [p_nchans-1:0]           in_val,
    output logic [p_nchans-1:0]           in_rdy,
    input  logic [p_nchans*p_nbits-1:0]   in_msg,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic [c_selbits-1:0]          out_sel
);

    // One extra bit so ptr + k never overflows before the modulo fold.
    localparam int unsigned c_idxbits = c_selbits + 1;
    localparam logic [c_idxbits-1:0] c_nchans = c_idxbits'(p_nchans);
    localparam logic [c_selbits-1:0] c_last   = c_selbits'(p_nchans - 1);

    logic                  out_val_q, out_val_d;
    logic [p_nbits-1:0]    out_msg_q, out_msg_d;
    logic [c_selbits-1:0]  out_sel_q, out_sel_d;
    logic [c_selbits-1:0]  ptr_q,     ptr_d;

    logic [p_nchans-1:0]   grant;
    logic [c_selbits-1:0]  gidx;
    logic                  found;
    logic [c_idxbits-1:0]  idx;
    logic [p_nbits-1:0]    sel_msg;
    logic                  can_accept;
    logic                  xfer;

    // Arbiter: first valid channel scanning from ptr (or from 0), wrapping.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < p_nchans; k++) begin
            idx = ((p_rr != 0) ? {1'b0, ptr_q} : '0) + c_idxbits'(k);
            if (idx >= c_nchans) begin
                idx = idx - c_nchans;
            end
            if (!found && in_val[idx[c_selbits-1:0]]) begin
                found                    = 1'b1;
                grant[idx[c_selbits-1:0]] = 1'b1;
                gidx                     = idx[c_selbits-1:0];
            end
        end
    end

    // Select the granted channel's payload.
    always_comb begin
        sel_msg = '0;
        for (int unsigned i = 0; i < p_nchans; i++) begin
            if (gidx == c_selbits'(i)) begin
                sel_msg = in_msg[i*p_nbits +: p_nbits];
            end
        end
    end

    assign can_accept = !out_val_q || out_rdy;
    assign xfer       = found && can_accept;
    // reset_n gating keeps in_rdy low while the register is held in reset.
    assign in_rdy     = (reset_n && can_accept) ? grant : '0;

    // Output register / pointer next state.
    always_comb begin
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        out_sel_d = out_sel_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            out_val_d = 1'b1;
            out_msg_d = sel_msg;
            out_sel_d = gidx;
            ptr_d     = (gidx == c_last) ? '0 : gidx + c_selbits'(1);
        end else if (out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            out_sel_q <= '0;
            ptr_q     <= '0;
        end else begin
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
            out_sel_q <= out_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_val = out_val_q;
    assign out_msg = out_msg_q;
    assign out_sel = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three instances (2-ch RR, 3-ch RR, 3-ch fixed
// priority, the last two sharing inputs) checked against a queue-free
// arithmetic reference model every cycle, plus directed vectors.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // Instance A: 2 channels, round-robin
    logic [1:0]  a_val, a_rdy;
    logic [7:0]  a_msg;
    logic        a_ordy, a_oval;
    logic [3:0]  a_omsg;
    logic [0:0]  a_osel;
    // Instances B (round-robin) and C (fixed) share inputs
    logic [2:0]  b_val, b_rdy, c_rdy;
    logic [11:0] b_msg;
    logic        b_ordy, b_oval, c_oval;
    logic [3:0]  b_omsg, c_omsg;
    logic [1:0]  b_osel, c_osel;

    stream_mux_rr #(.p_nbits(4), .p_nchans(2), .p_rr(1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_val(a_val), .in_rdy(a_rdy),
        .in_msg(a_msg), .out_val(a_oval), .out_rdy(a_ordy),
        .out_msg(a_omsg), .out_sel(a_osel));
    stream_mux_rr #(.p_nbits(4), .p_nchans(3), .p_rr(1)) u_b (
        .clk(clk), .reset_n(reset_n), .in_val(b_val), .in_rdy(b_rdy),
        .in_msg(b_msg), .out_val(b_oval), .out_rdy(b_ordy),
        .out_msg(b_omsg), .out_sel(b_osel));
    stream_mux_rr #(.p_nbits(4), .p_nchans(3), .p_rr(0)) u_c (
        .clk(clk), .reset_n(reset_n), .in_val(b_val), .in_rdy(c_rdy),
        .in_msg(b_msg), .out_val(c_oval), .out_rdy(b_ordy),
        .out_msg(c_omsg), .out_sel(c_osel));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state per instance
    int nch[3] = '{2, 3, 3};
    int rrm[3] = '{1, 1, 0};
    int m_val[3], m_msg[3], m_sel[3], m_ptr[3], e_g[3], o_rdy[3];

    function automatic int in_v(input int d);
        return (d == 0) ? int'(a_val) : int'(b_val);
    endfunction
    function automatic int in_m(input int d);
        return (d == 0) ? int'(a_msg) : int'(b_msg);
    endfunction
    function automatic int in_r(input int d);
        return (d == 0) ? int'(a_ordy) : int'(b_ordy);
    endfunction

    function automatic int dut_rdy(input int d);
        case (d)
            0:       return int'(a_rdy);
            1:       return int'(b_rdy);
            default: return int'(c_rdy);
        endcase
    endfunction
    function automatic int dut_val(input int d);
        case (d)
            0:       return int'(a_oval);
            1:       return int'(b_oval);
            default: return int'(c_oval);
        endcase
    endfunction
    function automatic int dut_msg(input int d);
        case (d)
            0:       return int'(a_omsg);
            1:       return int'(b_omsg);
            default: return int'(c_omsg);
        endcase
    endfunction
    function automatic int dut_sel(input int d);
        case (d)
            0:       return int'(a_osel);
            1:       return int'(b_osel);
            default: return int'(c_osel);
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_val[d] = 0; m_msg[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; e_g[d] = -1;
        end
    endtask

    // Which channel (if any) transfers at the coming edge.
    task automatic model_arb();
        for (int d = 0; d < 3; d++) begin
            int g;
            int ch;
            bit can;
            can = (m_val[d] == 0) || (in_r(d) != 0);
            g = -1;
            for (int k = 0; k < nch[d]; k++) begin
                ch = (rrm[d] != 0) ? (m_ptr[d] + k) % nch[d] : k;
                if (g < 0 && ((in_v(d) >> ch) & 1) != 0) g = ch;
            end
            e_g[d] = can ? g : -1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (e_g[d] >= 0) begin
                m_msg[d] = (in_m(d) >> (4 * e_g[d])) & 15;
                m_sel[d] = e_g[d];
                m_val[d] = 1;
                m_ptr[d] = (e_g[d] + 1) % nch[d];
            end else if (in_r(d) != 0) begin
                m_val[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out_val[%0d]", d), dut_val(d), m_val[d]);
            chk($sformatf("out_msg[%0d]", d), dut_msg(d), m_msg[d]);
            chk($sformatf("out_sel[%0d]", d), dut_sel(d), m_sel[d]);
        end
    endtask

    // One clock: check in_rdy at negedge, advance model at posedge, check outputs.
    task automatic cycle();
        @(negedge clk);
        model_arb();
        for (int d = 0; d < 3; d++) begin
            o_rdy[d] = dut_rdy(d);
            chk($sformatf("in_rdy[%0d]", d), o_rdy[d], (e_g[d] < 0) ? 0 : (1 << e_g[d]));
        end
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        for (int d = 0; d < 3; d++) chk($sformatf("rst_rdy[%0d]", d), dut_rdy(d), 0);
        @(posedge clk);
        #1;
        check_outputs();
        for (int d = 0; d < 3; d++) chk($sformatf("rst_rdy_hold[%0d]", d), dut_rdy(d), 0);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [11:0] m;
        logic        r;
        int b_rdy, b_sel, b_msg, c_rdy, c_sel, c_msg;
    } vec_t;
    vec_t tbl[10];

    initial begin
        // RR fairness rows then fixed-priority rows (B keeps rotating, C starves ch2)
        tbl[0] = '{3'b111, 12'hCBA, 1'b1, 1, 0, 10, 1, 0, 10};
        tbl[1] = '{3'b111, 12'hCBA, 1'b1, 2, 1, 11, 1, 0, 10};
        tbl[2] = '{3'b111, 12'hCBA, 1'b1, 4, 2, 12, 1, 0, 10};
        tbl[3] = '{3'b111, 12'hCBA, 1'b1, 1, 0, 10, 1, 0, 10};
        tbl[4] = '{3'b111, 12'hCBA, 1'b1, 2, 1, 11, 1, 0, 10};
        tbl[5] = '{3'b111, 12'hCBA, 1'b1, 4, 2, 12, 1, 0, 10};
        tbl[6] = '{3'b110, 12'hCBA, 1'b1, 2, 1, 11, 2, 1, 11};
        tbl[7] = '{3'b110, 12'hCBA, 1'b1, 4, 2, 12, 2, 1, 11};
        tbl[8] = '{3'b110, 12'hCBA, 1'b1, 2, 1, 11, 2, 1, 11};
        tbl[9] = '{3'b100, 12'hCBA, 1'b1, 4, 2, 12, 4, 2, 12};

        reset_n = 1'b0;
        a_val = 2'b11; a_msg = 8'h21; a_ordy = 1'b1;
        b_val = 3'b111; b_msg = 12'h000; b_ordy = 1'b1;
        #1;

        // Reset, then channel 0 first, channel 1 second
        apply_reset();
        b_val = 3'b000;
        cycle();
        chk("rst_first_sel", int'(a_osel), 0);
        chk("rst_first_msg", int'(a_omsg), 1);
        cycle();
        chk("rst_second_sel", int'(a_osel), 1);
        chk("rst_second_msg", int'(a_omsg), 2);

        // Table: round-robin fairness and fixed priority
        a_val = 2'b00;
        for (int i = 0; i < 10; i++) begin
            b_val = tbl[i].v; b_msg = tbl[i].m; b_ordy = tbl[i].r;
            cycle();
            chk($sformatf("row%0d b_rdy", i), o_rdy[1], tbl[i].b_rdy);
            chk($sformatf("row%0d b_val", i), int'(b_oval), 1);
            chk($sformatf("row%0d b_sel", i), int'(b_osel), tbl[i].b_sel);
            chk($sformatf("row%0d b_msg", i), int'(b_omsg), tbl[i].b_msg);
            chk($sformatf("row%0d c_rdy", i), o_rdy[2], tbl[i].c_rdy);
            chk($sformatf("row%0d c_sel", i), int'(c_osel), tbl[i].c_sel);
            chk($sformatf("row%0d c_msg", i), int'(c_omsg), tbl[i].c_msg);
        end
        b_val = 3'b000;

        // Backpressure: hold 5 from channel 1 for three stalled cycles
        a_val = 2'b10; a_msg = 8'h50; a_ordy = 1'b1;
        cycle();
        chk("bp_load_msg", int'(a_omsg), 5);
        a_val = 2'b11; a_msg = 8'h59; a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("bp%0d rdy", i), o_rdy[0], 0);
            chk($sformatf("bp%0d msg", i), int'(a_omsg), 5);
            chk($sformatf("bp%0d sel", i), int'(a_osel), 1);
            chk($sformatf("bp%0d val", i), int'(a_oval), 1);
        end
        a_ordy = 1'b1;
        cycle();
        chk("bp_release_rdy", o_rdy[0], 1);
        chk("bp_release_msg", int'(a_omsg), 9);
        chk("bp_release_sel", int'(a_osel), 0);

        // Simultaneous drain and fill, then idle drain
        a_val = 2'b10; a_msg = 8'h70;
        cycle();
        chk("fill_val", int'(a_oval), 1);
        chk("fill_msg", int'(a_omsg), 7);
        a_val = 2'b00;
        cycle();
        chk("idle_val", int'(a_oval), 0);
        chk("idle_msg", int'(a_omsg), 7);

        // Async reset mid-stream: ptr must restart at 0
        a_val = 2'b01; a_msg = 8'h03;
        b_val = 3'b001; b_msg = 12'h004;
        cycle();
        b_ordy = 1'b0;
        cycle();
        apply_reset();
        chk("mid_rst_a_val", int'(a_oval), 0);
        chk("mid_rst_b_val", int'(b_oval), 0);
        a_val = 2'b11; b_val = 3'b111; a_ordy = 1'b1; b_ordy = 1'b1;
        cycle();
        chk("post_rst_a_sel", int'(a_osel), 0);
        chk("post_rst_b_sel", int'(b_osel), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            a_val  = 2'($urandom_range(0, 3));
            b_val  = 3'($urandom_range(0, 7));
            a_msg  = 8'($urandom);
            b_msg  = 12'($urandom);
            a_ordy = ($urandom_range(0, 3) != 0);
            b_ordy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
